// File: rtl/uart_pkg.sv
// uart_pkg: shared FSM encoding and 8N1 frame constants for the buffered UART transmitter
package uart_pkg;
  typedef enum logic [2:0] {
    IDLE         = 3'd0,
    TX_START_BIT = 3'd1,
    TX_DATA_BITS = 3'd2,
    TX_STOP_BIT  = 3'd3,
    CLEANUP      = 3'd4
  } uart_state_e;
  localparam int DATA_BITS = 8;
  localparam logic START_LVL = 1'b0;
  localparam logic STOP_LVL = 1'b1;
endpackage

// File: rtl/uart_tx_buffered_if.sv
// uart_tx_buffered_if: byte write port plus serial and status outputs of the buffered transmitter
interface uart_tx_buffered_if #(parameter int FIFO_DEPTH = 4);
  logic                        i_TX_DV;
  logic [7:0]                  i_TX_Byte;
  logic                        o_TX_Ready;
  logic                        o_TX_Overflow;
  logic [$clog2(FIFO_DEPTH):0] o_FIFO_Count;
  logic                        o_TX_Serial;
  logic                        o_TX_Active;
  logic                        o_TX_Done;
  modport master (
    output i_TX_DV, i_TX_Byte,
    input  o_TX_Ready, o_TX_Overflow, o_FIFO_Count, o_TX_Serial, o_TX_Active, o_TX_Done
  );
  modport slave (
    input  i_TX_DV, i_TX_Byte,
    output o_TX_Ready, o_TX_Overflow, o_FIFO_Count, o_TX_Serial, o_TX_Active, o_TX_Done
  );
endinterface

// File: rtl/uart_tx_fifo.sv
// uart_tx_fifo: power-of-two byte FIFO with registered count and a write-while-full pulse
module uart_tx_fifo #(
  parameter int DEPTH = 4,
  parameter int WIDTH = 8
) (
  input  logic                     clk,
  input  logic                     rst_n,
  input  logic                     wr_en,
  input  logic [WIDTH-1:0]         wr_data,
  input  logic                     rd_en,
  output logic [WIDTH-1:0]         rd_data,
  output logic [$clog2(DEPTH):0]   count,
  output logic                     full,
  output logic                     empty,
  output logic                     overflow
);
  localparam int AW = $clog2(DEPTH);
  localparam int CW = AW + 1;
  logic [WIDTH-1:0] mem_q [DEPTH];
  logic [AW-1:0] wr_ptr_q, wr_ptr_d, rd_ptr_q, rd_ptr_d;
  logic [CW-1:0] count_q, count_d;
  logic ovf_q, ovf_d, wr, rd;
  // full comes from the registered count, so a same-cycle pop never rescues a write
  always_comb begin
    full = count_q == CW'(DEPTH);
    empty = count_q == '0;
    wr = wr_en && !full;
    rd = rd_en && !empty;
    ovf_d = wr_en && full;
    wr_ptr_d = wr_ptr_q + AW'(wr);
    rd_ptr_d = rd_ptr_q + AW'(rd);
    count_d = count_q + CW'(wr) - CW'(rd);
  end
  always_ff @(posedge clk) begin
    if (!rst_n) begin
      wr_ptr_q <= '0;
      rd_ptr_q <= '0;
      count_q <= '0;
      ovf_q <= 1'b0;
    end else begin
      wr_ptr_q <= wr_ptr_d;
      rd_ptr_q <= rd_ptr_d;
      count_q <= count_d;
      ovf_q <= ovf_d;
    end
  end
  always_ff @(posedge clk) begin
    if (wr) mem_q[wr_ptr_q] <= wr_data;
  end
  assign rd_data = mem_q[rd_ptr_q];
  assign count = count_q;
  assign overflow = ovf_q;
endmodule

// File: rtl/uart_tx_buffered.sv
// uart_tx_buffered: 8N1 UART transmitter draining a small byte FIFO, all line outputs registered
module uart_tx_buffered #(
  parameter int CLKS_PER_BIT = 217,
  parameter int FIFO_DEPTH = 4
) (
  input  logic               i_Clock,
  input  logic               i_Rst_L,
  uart_tx_buffered_if.slave  bus
);
  import uart_pkg::*;
  localparam int CNT_W = $clog2(CLKS_PER_BIT);
  localparam logic [CNT_W-1:0] CNT_LAST = CNT_W'(CLKS_PER_BIT - 1);
  uart_state_e state_q, state_d;
  logic [CNT_W-1:0] cnt_q, cnt_d;
  logic [2:0] bit_q, bit_d;
  logic [DATA_BITS-1:0] shift_q, shift_d, head;
  logic serial_q, serial_d, active_q, active_d, done_q, done_d;
  logic pop, empty, full, bit_end;
  uart_tx_fifo #(.DEPTH(FIFO_DEPTH), .WIDTH(DATA_BITS)) u_fifo (
    .clk(i_Clock),
    .rst_n(i_Rst_L),
    .wr_en(bus.i_TX_DV),
    .wr_data(bus.i_TX_Byte),
    .rd_en(pop),
    .rd_data(head),
    .count(bus.o_FIFO_Count),
    .full(full),
    .empty(empty),
    .overflow(bus.o_TX_Overflow)
  );
  // line outputs are decoded from the current state and registered, so they trail it by one cycle
  always_comb begin
    state_d = state_q;
    bit_d = bit_q;
    shift_d = shift_q;
    pop = 1'b0;
    bit_end = cnt_q == CNT_LAST;
    cnt_d = (bit_end || state_q inside {IDLE, CLEANUP}) ? '0 : cnt_q + 1'b1;
    case (state_q)
      IDLE: begin
        bit_d = '0;
        if (!empty) begin
          pop = 1'b1;
          shift_d = head;
          state_d = TX_START_BIT;
        end
      end
      TX_START_BIT: if (bit_end) state_d = TX_DATA_BITS;
      TX_DATA_BITS: if (bit_end) begin
        shift_d = shift_q >> 1;
        bit_d = bit_q + 1'b1;
        if (bit_q == 3'(DATA_BITS - 1)) state_d = TX_STOP_BIT;
      end
      TX_STOP_BIT: if (bit_end) state_d = CLEANUP;
      default: state_d = IDLE;
    endcase
    serial_d = state_q == TX_START_BIT ? START_LVL : state_q == TX_DATA_BITS ? shift_q[0] : STOP_LVL;
    active_d = state_q inside {TX_START_BIT, TX_DATA_BITS, TX_STOP_BIT};
    done_d = state_q == CLEANUP;
  end
  always_ff @(posedge i_Clock) begin
    if (!i_Rst_L) begin
      state_q <= IDLE;
      cnt_q <= '0;
      bit_q <= '0;
      shift_q <= '0;
      serial_q <= STOP_LVL;
      active_q <= 1'b0;
      done_q <= 1'b0;
    end else begin
      state_q <= state_d;
      cnt_q <= cnt_d;
      bit_q <= bit_d;
      shift_q <= shift_d;
      serial_q <= serial_d;
      active_q <= active_d;
      done_q <= done_d;
    end
  end
  assign bus.o_TX_Ready = !full;
  assign bus.o_TX_Serial = serial_q;
  assign bus.o_TX_Active = active_q;
  assign bus.o_TX_Done = done_q;
endmodule

// File: tb/tb_uart_tx_buffered.sv
// tb_uart_tx_buffered: scenario tasks checked against a frame-schedule reference model
module tb_uart_tx_buffered;
  localparam int C = 4;
  localparam int D = 4;
  localparam int P = 10 * C + 2;
  localparam int FRAME = 10 * C;
  logic clk = 1'b0;
  logic rst_l = 1'b0;
  int checks = 0;
  int errors = 0;
  uart_tx_buffered_if #(.FIFO_DEPTH(D)) bus ();
  uart_tx_buffered #(.CLKS_PER_BIT(C), .FIFO_DEPTH(D)) dut (
    .i_Clock(clk),
    .i_Rst_L(rst_l),
    .bus(bus.slave)
  );
  always #5 clk = ~clk;
  // model: queued bytes, next edge the transmitter may pop, and start edge of the current frame
  logic [7:0] q[$];
  int t = 0;
  int free_at = 0;
  int cur_s = -1000;
  logic [7:0] cur_b = 8'h00;
  logic exp_serial, exp_active, exp_done, exp_ovf, exp_ready;
  logic [$clog2(D):0] exp_count;

  task automatic tick(input logic dv, input logic [7:0] b, input logic rn = 1'b1);
    int d, k;
    bus.i_TX_DV = dv;
    bus.i_TX_Byte = b;
    rst_l = rn;
    @(posedge clk);
    t++;
    if (!rn) begin
      q.delete();
      free_at = t + 1;
      cur_s = -1000;
      exp_ovf = 1'b0;
    end else begin
      exp_ovf = dv && q.size() == D;
      if (t >= free_at && q.size() > 0) begin
        cur_b = q.pop_front();
        cur_s = t;
        free_at = t + P;
      end
      if (dv && !exp_ovf) q.push_back(b);
    end
    d = t - cur_s;
    k = (d - 1) / C;
    exp_active = d >= 1 && d <= FRAME;
    exp_serial = !exp_active ? 1'b1 : (k == 0) ? 1'b0 : (k == 9) ? 1'b1 : cur_b[k-1];
    exp_done = d == FRAME + 1;
    exp_count = ($clog2(D)+1)'(q.size());
    exp_ready = q.size() < D;
    #1;
  endtask

  task automatic test_reset;
    repeat (3) tick(1'b0, 8'h00, 1'b0);
    checks += 6;
    if (bus.o_TX_Serial !== 1'b1) begin errors++; $display("FAIL reset_serial got %b exp 1", bus.o_TX_Serial); end
    if (bus.o_TX_Active !== 1'b0) begin errors++; $display("FAIL reset_active got %b exp 0", bus.o_TX_Active); end
    if (bus.o_TX_Done !== 1'b0) begin errors++; $display("FAIL reset_done got %b exp 0", bus.o_TX_Done); end
    if (bus.o_TX_Overflow !== 1'b0) begin errors++; $display("FAIL reset_ovf got %b exp 0", bus.o_TX_Overflow); end
    if (bus.o_FIFO_Count !== 3'd0) begin errors++; $display("FAIL reset_count got %0d exp 0", bus.o_FIFO_Count); end
    if (bus.o_TX_Ready !== 1'b1) begin errors++; $display("FAIL reset_ready got %b exp 1", bus.o_TX_Ready); end
    repeat (3) begin
      tick(1'b0, 8'hFF);
      checks++;
      if (bus.o_TX_Serial !== 1'b1 || bus.o_FIFO_Count !== exp_count) begin
        errors++; $display("FAIL idle_after_reset serial %b count %0d exp 1 %0d", bus.o_TX_Serial, bus.o_FIFO_Count, exp_count);
      end
    end
  endtask

  task automatic test_single_a5;
    logic [9:0] pat = 10'b1101001010;
    int n0, rel;
    int done_n = 0, act_n = 0, first_low = -1;
    tick(1'b1, 8'hA5);
    n0 = t;
    repeat (FRAME + 15) begin
      tick(1'b0, $urandom);
      checks++;
      if (bus.o_TX_Serial !== exp_serial || bus.o_TX_Active !== exp_active || bus.o_TX_Done !== exp_done) begin
        errors++; $display("FAIL a5_frame t=%0d ser/act/done %b%b%b exp %b%b%b", t, bus.o_TX_Serial, bus.o_TX_Active, bus.o_TX_Done, exp_serial, exp_active, exp_done);
      end
      rel = t - n0 - 2;
      if (rel >= 0 && rel < FRAME && rel % C == 1) begin
        checks++;
        if (bus.o_TX_Serial !== pat[rel/C]) begin errors++; $display("FAIL a5_bit%0d got %b exp %b", rel / C, bus.o_TX_Serial, pat[rel/C]); end
      end
      if (bus.o_TX_Done === 1'b1) done_n++;
      if (bus.o_TX_Active === 1'b1) act_n++;
      if (bus.o_TX_Serial === 1'b0 && first_low < 0) first_low = t;
    end
    checks += 3;
    if (done_n != 1) begin errors++; $display("FAIL a5_done_pulses got %0d exp 1", done_n); end
    if (act_n != FRAME) begin errors++; $display("FAIL a5_active_cycles got %0d exp %0d", act_n, FRAME); end
    if (first_low != n0 + 2) begin errors++; $display("FAIL a5_latency got %0d exp %0d", first_low - n0, 2); end
  endtask

  task automatic test_back_to_back;
    logic [7:0] bytes [3] = '{8'h00, 8'hFF, 8'h3C};
    int peak = 0, done_n = 0;
    for (int i = 0; i < 3 + 3 * P + 10; i++) begin
      tick(i < 3, i < 3 ? bytes[i] : 8'h00);
      checks++;
      if (bus.o_TX_Serial !== exp_serial || bus.o_FIFO_Count !== exp_count || bus.o_TX_Done !== exp_done) begin
        errors++; $display("FAIL b2b t=%0d ser %b cnt %0d done %b exp %b %0d %b", t, bus.o_TX_Serial, bus.o_FIFO_Count, bus.o_TX_Done, exp_serial, exp_count, exp_done);
      end
      if (int'(bus.o_FIFO_Count) > peak) peak = int'(bus.o_FIFO_Count);
      if (bus.o_TX_Done === 1'b1) done_n++;
    end
    checks += 2;
    if (peak != 2) begin errors++; $display("FAIL b2b_peak_count got %0d exp 2", peak); end
    if (done_n != 3) begin errors++; $display("FAIL b2b_frames got %0d exp 3", done_n); end
  endtask

  task automatic test_overflow;
    int ovf_n = 0, done_n = 0;
    for (int i = 0; i < 6 + 5 * P + 10; i++) begin
      tick(i < 6, 8'($urandom));
      checks++;
      if (bus.o_TX_Overflow !== exp_ovf || bus.o_TX_Ready !== exp_ready || bus.o_FIFO_Count !== exp_count || bus.o_TX_Serial !== exp_serial) begin
        errors++; $display("FAIL ovf t=%0d ovf %b rdy %b cnt %0d ser %b exp %b %b %0d %b", t, bus.o_TX_Overflow, bus.o_TX_Ready, bus.o_FIFO_Count, bus.o_TX_Serial, exp_ovf, exp_ready, exp_count, exp_serial);
      end
      if (i == 4) begin
        checks++;
        if (bus.o_TX_Ready !== 1'b0) begin errors++; $display("FAIL ovf_ready_when_full got %b exp 0", bus.o_TX_Ready); end
      end
      if (bus.o_TX_Overflow === 1'b1) ovf_n++;
      if (bus.o_TX_Done === 1'b1) done_n++;
    end
    checks += 2;
    if (ovf_n != 1) begin errors++; $display("FAIL ovf_pulses got %0d exp 1", ovf_n); end
    if (done_n != 5) begin errors++; $display("FAIL ovf_frames got %0d exp 5", done_n); end
  endtask

  task automatic test_reset_mid_frame;
    int guard = 0, done_n = 0, low_n = 0;
    tick(1'b1, 8'h55);
    tick(1'b1, 8'($urandom));
    tick(1'b1, 8'($urandom));
    while (!(t > cur_s && (t - cur_s - 1) / C == 4) && guard < 200) begin
      tick(1'b0, 8'h00);
      guard++;
    end
    checks += 2;
    if (guard >= 200) begin errors++; $display("FAIL midrst_reach_bit3 got timeout exp bit3"); end
    if (bus.o_TX_Serial !== 1'b0) begin errors++; $display("FAIL midrst_bit3_level got %b exp 0", bus.o_TX_Serial); end
    tick(1'b0, 8'h00, 1'b0);
    checks += 3;
    if (bus.o_TX_Serial !== 1'b1) begin errors++; $display("FAIL midrst_line got %b exp 1", bus.o_TX_Serial); end
    if (bus.o_FIFO_Count !== 3'd0) begin errors++; $display("FAIL midrst_count got %0d exp 0", bus.o_FIFO_Count); end
    if (bus.o_TX_Active !== 1'b0) begin errors++; $display("FAIL midrst_active got %b exp 0", bus.o_TX_Active); end
    repeat (2 * P) begin
      tick(1'b0, 8'h00);
      if (bus.o_TX_Done === 1'b1) done_n++;
      if (bus.o_TX_Serial !== 1'b1) low_n++;
    end
    checks += 2;
    if (done_n != 0) begin errors++; $display("FAIL midrst_done_pulses got %0d exp 0", done_n); end
    if (low_n != 0) begin errors++; $display("FAIL midrst_line_low_cycles got %0d exp 0", low_n); end
  endtask

  task automatic test_latency_81;
    tick(1'b1, 8'h81);
    tick(1'b0, 8'h00);
    checks++;
    if (bus.o_TX_Serial !== 1'b1) begin errors++; $display("FAIL lat81_n1 got %b exp 1", bus.o_TX_Serial); end
    tick(1'b0, 8'h00);
    checks++;
    if (bus.o_TX_Serial !== 1'b0) begin errors++; $display("FAIL lat81_n2 got %b exp 0", bus.o_TX_Serial); end
    repeat (P) begin
      tick(1'b0, 8'h00);
      checks++;
      if (bus.o_TX_Serial !== exp_serial) begin errors++; $display("FAIL lat81_frame t=%0d got %b exp %b", t, bus.o_TX_Serial, exp_serial); end
    end
  endtask

  task automatic test_random;
    int pct;
    for (int i = 0; i < 2400; i++) begin
      pct = ((i / 300) % 2 == 1) ? 90 : 4;
      tick($urandom_range(0, 99) < pct, 8'($urandom), $urandom_range(0, 599) != 0);
      checks++;
      if (bus.o_TX_Serial !== exp_serial || bus.o_TX_Active !== exp_active || bus.o_TX_Done !== exp_done ||
          bus.o_TX_Overflow !== exp_ovf || bus.o_TX_Ready !== exp_ready || bus.o_FIFO_Count !== exp_count) begin
        errors++;
        $display("FAIL random t=%0d ser/act/done/ovf/rdy %b%b%b%b%b cnt %0d exp %b%b%b%b%b %0d", t,
                 bus.o_TX_Serial, bus.o_TX_Active, bus.o_TX_Done, bus.o_TX_Overflow, bus.o_TX_Ready, bus.o_FIFO_Count,
                 exp_serial, exp_active, exp_done, exp_ovf, exp_ready, exp_count);
      end
    end
  endtask

  initial begin
    bus.i_TX_DV = 1'b0;
    bus.i_TX_Byte = 8'h00;
    test_reset();
    test_single_a5();
    test_back_to_back();
    test_overflow();
    test_reset_mid_frame();
    test_latency_81();
    test_random();
    $display("Simulation finished: %0d checks, %0d errors", checks, errors);
    $finish;
  end
endmodule

// File: doc/uart_tx_buffered.md
UART_TX_BUFFERED -- requirements
Module: uart_tx_buffered

Interface
REQ-001 SHALL have parameter CLKS_PER_BIT, default 217; clocks per serial bit, equal to f_clk/baud, minimum 4.
REQ-002 SHALL have parameter FIFO_DEPTH, default 4; byte entries in the transmit FIFO, a power of two, minimum 2.
REQ-003 SHALL have port i_Clock, input, 1; single clock for all logic.
REQ-004 SHALL have port i_Rst_L, input, 1; reset, synchronous and active-low.
REQ-005 SHALL have port i_TX_DV, input, 1; write strobe, byte accepted when high and o_TX_Ready high.
REQ-006 SHALL have port i_TX_Byte, input, 8; byte to queue.
REQ-007 SHALL have port o_TX_Ready, output, 1; FIFO not full.
REQ-008 SHALL have port o_TX_Overflow, output, 1; one-cycle pulse, write attempted while full.
REQ-009 SHALL have port o_FIFO_Count, output, $clog2(FIFO_DEPTH)+1; current FIFO occupancy.
REQ-010 SHALL have port o_TX_Serial, output, 1; serial line, idle high.
REQ-011 SHALL have port o_TX_Active, output, 1; high from start bit through stop bit.
REQ-012 SHALL have port o_TX_Done, output, 1; one-cycle pulse after each stop bit.

Function
REQ-013 Frame SHALL be 8N1: one start bit (0), 8 data bits LSB first, one stop bit (1).
REQ-014 Each bit SHALL hold o_TX_Serial for exactly CLKS_PER_BIT cycles.
REQ-015 FSM states SHALL be IDLE, TX_START_BIT, TX_DATA_BITS, TX_STOP_BIT, CLEANUP.
REQ-016 IDLE SHALL pop the FIFO head into the shift register when the FIFO is non-empty and then go to TX_START_BIT; otherwise it SHALL stay in IDLE with the line high.
REQ-017 TX_DATA_BITS SHALL use a 3-bit bit index 0..7 and go to TX_STOP_BIT after bit 7 completes.
REQ-018 TX_STOP_BIT SHALL go to CLEANUP after CLKS_PER_BIT cycles; CLEANUP SHALL last 1 cycle with o_TX_Done=1 and the line high, then go to IDLE.
REQ-019 o_TX_Serial, o_TX_Active and o_TX_Done SHALL be registered.
REQ-020 Latency SHALL be fixed: a write to an empty FIFO in IDLE sampled at edge N drives o_TX_Serial low from edge N+2.
REQ-021 Back-to-back queued bytes SHALL be separated by exactly 2 extra high cycles after the stop bit (CLEANUP plus IDLE).
REQ-022 The FIFO SHALL preserve write order, with read and write pointers wrapping modulo FIFO_DEPTH.
REQ-023 A write while full SHALL be dropped and SHALL pulse o_TX_Overflow, even if a pop occurs in the same cycle; o_TX_Ready SHALL derive from the registered count.
REQ-024 A simultaneous write and pop with the FIFO not full SHALL leave the count unchanged.
REQ-025 The clock counter SHALL be $clog2(CLKS_PER_BIT) bits wide and cleared at every bit boundary.
REQ-026 i_TX_Byte SHALL be ignored when i_TX_DV is low.

Reset
REQ-027 With i_Rst_L low at a clock edge, the block SHALL set state to IDLE and counters, bit index and FIFO pointers to 0.
REQ-028 Reset values SHALL be: o_TX_Serial=1, o_TX_Active=0, o_TX_Done=0, o_TX_Overflow=0, o_FIFO_Count=0, o_TX_Ready=1.
REQ-029 Reset mid-frame SHALL abort the frame, drive the line high at that edge and discard queued bytes.

Structure
REQ-030 Package uart_pkg SHALL hold the FSM state enum (3-bit encoding, IDLE=0) and the frame constants (8 data bits, start level 0, stop level 1).
REQ-031 FIFO storage and pointers SHALL be one sub-module, uart_tx_fifo, parameterised by FIFO_DEPTH and width 8.
REQ-032 The bit FSM and shift register SHALL reside in uart_tx_buffered.

Verification (CLKS_PER_BIT=4, FIFO_DEPTH=4)
REQ-033 Write 0xA5 once -> line shows 0,1,0,1,0,0,1,0,1,1, each bit held 4 cycles; o_TX_Done pulses once; o_TX_Active is high for 40 cycles.
REQ-034 Write 0x00, 0xFF, 0x3C on consecutive cycles -> three frames in that order, each separated by exactly 2 extra high cycles; o_FIFO_Count peaks at 2.
REQ-035 Write 6 bytes on consecutive cycles while idle -> first pops; next 4 queue; 6th drops with o_TX_Overflow high 1 cycle and o_TX_Ready low; 5 frames are sent.
REQ-036 Assert i_Rst_L low during data bit 3 of 0x55 with 2 bytes queued -> line high at that edge; count 0; no further frames; o_TX_Done never pulses.
REQ-037 Write 0x81 into an empty idle FIFO at edge N -> line low at edge N+2.
